// File: rtl/spi_frame_slave.sv
// SPI mode-0 responder: oversamples cs/sclk/mosi on clk, receives one FRAME_W-bit frame MSB-first
// while returning a preloaded response frame on miso.
module spi_frame_slave #(
    parameter int FRAME_W = 392,
    parameter int CNT_W   = 9
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cs,
    input  logic               sclk,
    input  logic               mosi,
    output logic               miso,
    input  logic [FRAME_W-1:0] tx_data,
    input  logic               tx_load,
    output logic [FRAME_W-1:0] rx_data,
    output logic               rx_valid,
    output logic               rx_err,
    output logic               busy
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FRAME_W);

    // Synchronizer flops reset low so a reset taken while cs is held low
    // cannot manufacture a cs_fall and re-enter SHIFT mid-frame.
    logic [1:0] cs_sync_q, sck_sync_q, mosi_sync_q;
    logic       cs_hist_q, sck_hist_q;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [FRAME_W-1:0] rx_sr_q, rx_sr_d;
    logic [FRAME_W-1:0] tx_sr_q, tx_sr_d;
    logic [FRAME_W-1:0] tx_buf_q, tx_buf_d;
    logic [FRAME_W-1:0] rx_data_q, rx_data_d;
    logic               ovr_q, ovr_d;
    logic               rx_valid_q, rx_valid_d;
    logic               rx_err_q, rx_err_d;

    logic cs_s, cs_fall, cs_rise, sck_rise, sck_fall, mosi_s;

    always_ff @(posedge clk) begin
        if (reset) begin
            cs_sync_q   <= '0;
            sck_sync_q  <= '0;
            mosi_sync_q <= '0;
            cs_hist_q   <= 1'b0;
            sck_hist_q  <= 1'b0;
        end else begin
            cs_sync_q   <= {cs_sync_q[0], cs};
            sck_sync_q  <= {sck_sync_q[0], sclk};
            mosi_sync_q <= {mosi_sync_q[0], mosi};
            cs_hist_q   <= cs_sync_q[1];
            sck_hist_q  <= sck_sync_q[1];
        end
    end

    assign cs_s     = cs_sync_q[1];
    assign cs_fall  = cs_hist_q & ~cs_s;
    assign cs_rise  = ~cs_hist_q & cs_s;
    assign sck_rise = ~sck_hist_q & sck_sync_q[1];
    assign sck_fall = sck_hist_q & ~sck_sync_q[1];
    assign mosi_s   = mosi_sync_q[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            rx_sr_q    <= '0;
            tx_sr_q    <= '0;
            tx_buf_q   <= '0;
            rx_data_q  <= '0;
            ovr_q      <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            rx_sr_q    <= rx_sr_d;
            tx_sr_q    <= tx_sr_d;
            tx_buf_q   <= tx_buf_d;
            rx_data_q  <= rx_data_d;
            ovr_q      <= ovr_d;
            rx_valid_q <= rx_valid_d;
            rx_err_q   <= rx_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        rx_sr_d    = rx_sr_q;
        tx_sr_d    = tx_sr_q;
        rx_data_d  = rx_data_q;
        ovr_d      = ovr_q;
        rx_valid_d = 1'b0;
        rx_err_d   = 1'b0;
        tx_buf_d   = tx_load ? tx_data : tx_buf_q;

        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    // A load on the same cycle bypasses tx_buf so it lands in this frame.
                    tx_sr_d   = tx_load ? tx_data : tx_buf_q;
                    bit_cnt_d = '0;
                    ovr_d     = 1'b0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    state_d = DONE;
                end else begin
                    if (sck_rise) begin
                        if (bit_cnt_q == FULL_CNT) begin
                            ovr_d = 1'b1;
                        end else begin
                            rx_sr_d   = {rx_sr_q[FRAME_W-2:0], mosi_s};
                            bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        end
                    end
                    if (sck_fall) begin
                        tx_sr_d = tx_sr_q << 1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                if (bit_cnt_q == FULL_CNT && !ovr_q) begin
                    rx_data_d  = rx_sr_q;
                    rx_valid_d = 1'b1;
                end else begin
                    rx_err_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy     = (state_q == SHIFT);
    assign miso     = busy & tx_sr_q[FRAME_W-1];
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign rx_err   = rx_err_q;

endmodule

// File: tb/tb_spi_frame_slave.sv
// Bench for spi_frame_slave: a behavioural SPI master drives frames and a frame-level
// model predicts rx_data, the pulses and the bits returned on miso.
module tb_spi_frame_slave;

    localparam int FRAME_W = 392;
    localparam int CNT_W   = 9;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               cs = 1'b1;
    logic               sclk = 1'b0;
    logic               mosi = 1'b0;
    logic               miso;
    logic [FRAME_W-1:0] tx_data = '0;
    logic               tx_load = 1'b0;
    logic [FRAME_W-1:0] rx_data;
    logic               rx_valid;
    logic               rx_err;
    logic               busy;

    int total = 0;
    int bad = 0;
    int v_total = 0;
    int e_total = 0;

    // Reference model: response buffer contents and last accepted frame.
    logic [FRAME_W-1:0] model_buf = '0;
    logic [FRAME_W-1:0] model_rx = '0;

    spi_frame_slave #(.FRAME_W(FRAME_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .cs(cs), .sclk(sclk), .mosi(mosi), .miso(miso),
        .tx_data(tx_data), .tx_load(tx_load), .rx_data(rx_data),
        .rx_valid(rx_valid), .rx_err(rx_err), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid) v_total++;
        if (rx_err) e_total++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [FRAME_W-1:0] rand_word();
        logic [FRAME_W-1:0] w = '0;
        for (int j = 0; j < 13; j++) w = {w[FRAME_W-33:0], 32'($urandom)};
        return w;
    endfunction

    task automatic spi_bit(input logic b, output logic m);
        mosi = b;
        repeat (5) @(negedge clk);
        m = miso;
        sclk = 1'b1;
        repeat (5) @(negedge clk);
        sclk = 1'b0;
    endtask

    task automatic load_tx(input logic [FRAME_W-1:0] val);
        @(negedge clk);
        tx_data = val;
        tx_load = 1'b1;
        @(negedge clk);
        tx_load = 1'b0;
        model_buf = val;
    endtask

    // Runs one frame of nbits sclk pulses; optionally pulses tx_load before bit load_at.
    task automatic run_frame(input logic [FRAME_W-1:0] word, input int nbits,
                             input int load_at, input logic [FRAME_W-1:0] load_val,
                             output logic [FRAME_W-1:0] cap, output int nv, output int ne,
                             output int lat, output int both);
        logic m;
        cap = '0;
        nv = 0; ne = 0; lat = -1; both = 0;
        cs = 1'b0;
        repeat (6) @(negedge clk);
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL busy_in_frame: got %b want 1", busy);
        end
        for (int i = 0; i < nbits; i++) begin
            if (i == load_at) begin
                tx_data = load_val;
                tx_load = 1'b1;
                @(negedge clk);
                tx_load = 1'b0;
            end
            spi_bit((i < FRAME_W) ? word[FRAME_W-1-i] : 1'($urandom), m);
            if (i < FRAME_W) cap[FRAME_W-1-i] = m;
        end
        repeat (5) @(negedge clk);
        cs = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (rx_valid) begin nv++; lat = k; end
            if (rx_err) ne++;
            if (rx_valid && rx_err) both++;
        end
        if (load_at >= 0 && load_at < nbits) model_buf = load_val;
    endtask

    // Checks one completed frame against the model and updates model_rx.
    task automatic check_frame(input string name, input logic [FRAME_W-1:0] word,
                               input int nbits, input logic [FRAME_W-1:0] exp_miso,
                               input logic [FRAME_W-1:0] cap, input int nv, input int ne,
                               input int lat, input int both);
        int ev, ee;
        ev = (nbits == FRAME_W) ? 1 : 0;
        ee = 1 - ev;
        if (ev == 1) model_rx = word;
        total++;
        if (nv != ev || ne != ee || both != 0) begin
            bad++;
            $display("FAIL %s_pulses: valid=%0d err=%0d both=%0d want valid=%0d err=%0d",
                     name, nv, ne, both, ev, ee);
        end
        total++;
        if (rx_data !== model_rx) begin
            bad++;
            $display("FAIL %s_rx_data: got %h want %h", name, rx_data, model_rx);
        end
        total++;
        if (cap !== exp_miso) begin
            bad++;
            $display("FAIL %s_miso: got %h want %h", name, cap, exp_miso);
        end
        if (ev == 1) begin
            total++;
            if (lat != 4) begin
                bad++;
                $display("FAIL %s_latency: got %0d want 4", name, lat);
            end
        end
    endtask

    task automatic frame(input string name, input logic [FRAME_W-1:0] word, input int nbits);
        logic [FRAME_W-1:0] cap, exp_m;
        int nv, ne, lat, both;
        exp_m = model_buf;
        run_frame(word, nbits, -1, '0, cap, nv, ne, lat, both);
        check_frame(name, word, nbits, exp_m, cap, nv, ne, lat, both);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({rx_data, rx_valid, rx_err, busy, miso} !== '0) begin
            bad++;
            $display("FAIL reset_state: rx_data=%h valid=%b err=%b busy=%b miso=%b",
                     rx_data, rx_valid, rx_err, busy, miso);
        end
        reset = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_full_frame();
        frame("full", {128'h00112233445566778899aabbccddeeff, 8'd16,
                       128'h000102030405060708090a0b0c0d0e0f, 128'h0}, FRAME_W);
    endtask

    task automatic test_tx_load();
        load_tx({8'h00, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 256'h0});
        frame("txload", rand_word(), FRAME_W);
        repeat (3) @(negedge clk);
        total++;
        if (miso !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL idle_miso: miso=%b busy=%b want 0 0", miso, busy);
        end
    endtask

    task automatic test_short();
        frame("short", rand_word(), 200);
    endtask

    task automatic test_overrun();
        frame("overrun", rand_word(), FRAME_W + 1);
        frame("after_ovr", rand_word(), FRAME_W);
    endtask

    task automatic test_reset_mid();
        logic m;
        int v0, e0;
        load_tx(rand_word());
        v0 = v_total; e0 = e_total;
        cs = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = 0; i < 100; i++) spi_bit(1'($urandom), m);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if ({rx_data, rx_valid, rx_err, busy, miso} !== '0) begin
            bad++;
            $display("FAIL reset_mid_state: rx_data=%h valid=%b err=%b busy=%b miso=%b",
                     rx_data, rx_valid, rx_err, busy, miso);
        end
        reset = 1'b0;
        model_buf = '0;
        model_rx = '0;
        repeat (3) @(negedge clk);
        cs = 1'b1;
        repeat (10) @(negedge clk);
        total++;
        if (v_total != v0 || e_total != e0) begin
            bad++;
            $display("FAIL reset_mid_pulses: valid=%0d err=%0d want 0 0",
                     v_total - v0, e_total - e0);
        end
        frame("post_reset", rand_word(), FRAME_W);
    endtask

    task automatic test_tx_load_mid();
        logic [FRAME_W-1:0] cap, exp_m, w;
        int nv, ne, lat, both;
        load_tx(rand_word());
        exp_m = model_buf;
        w = rand_word();
        run_frame(w, FRAME_W, 50, {{(FRAME_W-1){1'b0}}, 1'b1}, cap, nv, ne, lat, both);
        check_frame("load_mid", w, FRAME_W, exp_m, cap, nv, ne, lat, both);
        frame("next_after_load", rand_word(), FRAME_W);
    endtask

    task automatic test_back_to_back();
        load_tx(rand_word());
        frame("b2b_a", rand_word(), FRAME_W);
        frame("b2b_b", rand_word(), FRAME_W);
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_tx_load();
        test_short();
        test_overrun();
        test_reset_mid();
        test_tx_load_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
